// File: rtl/ula_param_seq_if.sv
// Operand/result bundle for ula_param_seq: operand handshake in, result handshake out.
interface ula_param_seq_if #(
    parameter int unsigned N = 8
) ();
    logic         valid_in;
    logic         ready_in;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   seletor;
    logic         carry_in;
    logic         valid_out;
    logic         ready_out;
    logic [N-1:0] resultado;
    logic [N-1:0] resultado_hi;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         propagado;
    logic         gerado;

    // ALU side
    modport slave (
        input  valid_in, A, B, seletor, carry_in, ready_out,
        output ready_in, valid_out, resultado, resultado_hi,
        output carry_out, overflow, zero, propagado, gerado
    );

    // Operand source / result sink side
    modport master (
        output valid_in, A, B, seletor, carry_in, ready_out,
        input  ready_in, valid_out, resultado, resultado_hi,
        input  carry_out, overflow, zero, propagado, gerado
    );
endinterface

// File: rtl/ula_param_seq.sv
// Registered ALU: carry-lookahead add/sub, logic ops and an N-cycle shift-add multiplier.
module ula_param_seq #(
    parameter int unsigned N = 8
) (
    input  logic            clk,
    input  logic            rst,
    ula_param_seq_if.slave  bus
);
    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpNot  = 3'b010;
    localparam logic [2:0] OpNand = 3'b011;
    localparam logic [2:0] OpAdd  = 3'b100;
    localparam logic [2:0] OpSub  = 3'b101;
    localparam logic [2:0] OpMul  = 3'b110;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_count, w_count_nxt;
    logic [2*N-1:0]  r_mcand, w_mcand_nxt;
    logic [N-1:0]    r_mplier, w_mplier_nxt;
    logic [2*N-1:0]  r_acc, w_acc_nxt;
    logic            r_valid, w_valid_nxt;
    logic [N-1:0]    r_res, w_res_nxt;
    logic [N-1:0]    r_res_hi, w_res_hi_nxt;
    logic            r_co, w_co_nxt;
    logic            r_ov, w_ov_nxt;
    logic            r_z, w_z_nxt;
    logic            r_p, w_p_nxt;
    logic            r_g, w_g_nxt;

    logic [N-1:0]    w_bp;
    logic [N-1:0]    w_gen;
    logic [N-1:0]    w_prop;
    logic [N:0]      w_c;
    logic [N:0]      w_c0;
    logic [N-1:0]    w_sum;

    logic [N-1:0]    w_lres;
    logic            w_lco, w_lov, w_lp, w_lg;
    logic [2*N-1:0]  w_acc_step;
    logic            w_ready_in;
    logic            w_accept;

    // Lookahead chain; w_c0 runs the same chain with no carry-in to form the group generate
    always_comb begin
        w_bp    = (bus.seletor == OpSub) ? ~bus.B : bus.B;
        w_c     = '0;
        w_c0    = '0;
        w_gen   = '0;
        w_prop  = '0;
        w_c[0]  = (bus.seletor == OpSub) ? 1'b1 : bus.carry_in;
        w_c0[0] = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_gen[i]    = bus.A[i] & w_bp[i];
            w_prop[i]   = bus.A[i] | w_bp[i];
            w_c[i+1]    = w_gen[i] | (w_prop[i] & w_c[i]);
            w_c0[i+1]   = w_gen[i] | (w_prop[i] & w_c0[i]);
        end
        w_sum = bus.A ^ w_bp ^ w_c[N-1:0];
    end

    // Single-cycle operation results and flags
    always_comb begin
        w_lres = '0;
        w_lco  = 1'b0;
        w_lov  = 1'b0;
        w_lp   = 1'b0;
        w_lg   = 1'b0;
        case (bus.seletor)
            OpAnd:  w_lres = bus.A & bus.B;
            OpOr:   w_lres = bus.A | bus.B;
            OpNot:  w_lres = ~bus.A;
            OpNand: w_lres = ~(bus.A & bus.B);
            OpAdd, OpSub: begin
                w_lres = w_sum;
                w_lco  = w_c[N];
                w_lov  = w_c[N] ^ w_c[N-1];
                w_lp   = &w_prop;
                w_lg   = w_c0[N];
            end
            default: w_lres = '0;
        endcase
    end

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_ready_in = (r_state == StIdle) && (!r_valid || bus.ready_out) && !rst;
    assign w_accept   = bus.valid_in && w_ready_in;

    // Next-state: handshake, result loading and multiplier iteration
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_valid_nxt  = r_valid;
        w_res_nxt    = r_res;
        w_res_hi_nxt = r_res_hi;
        w_co_nxt     = r_co;
        w_ov_nxt     = r_ov;
        w_z_nxt      = r_z;
        w_p_nxt      = r_p;
        w_g_nxt      = r_g;

        // A taken result is dropped unless replaced below
        if (r_valid && bus.ready_out) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (bus.seletor == OpMul) begin
                        w_mcand_nxt  = {{N{1'b0}}, bus.A};
                        w_mplier_nxt = bus.B;
                        w_acc_nxt    = '0;
                        w_count_nxt  = '0;
                        w_state_nxt  = StMul;
                    end else begin
                        w_res_nxt    = w_lres;
                        w_res_hi_nxt = '0;
                        w_co_nxt     = w_lco;
                        w_ov_nxt     = w_lov;
                        w_z_nxt      = (w_lres == '0);
                        w_p_nxt      = w_lp;
                        w_g_nxt      = w_lg;
                        w_valid_nxt  = 1'b1;
                    end
                end
            end
            StMul: begin
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_count_nxt  = r_count + 1'b1;
                if (r_count == CntW'(N - 1)) begin
                    w_state_nxt  = StIdle;
                    w_count_nxt  = '0;
                    w_res_nxt    = w_acc_step[N-1:0];
                    w_res_hi_nxt = w_acc_step[2*N-1:N];
                    w_co_nxt     = 1'b0;
                    w_ov_nxt     = 1'b0;
                    w_z_nxt      = (w_acc_step == '0);
                    w_p_nxt      = 1'b0;
                    w_g_nxt      = 1'b0;
                    w_valid_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_valid  <= 1'b0;
            r_res    <= '0;
            r_res_hi <= '0;
            r_co     <= 1'b0;
            r_ov     <= 1'b0;
            r_z      <= 1'b0;
            r_p      <= 1'b0;
            r_g      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_valid  <= w_valid_nxt;
            r_res    <= w_res_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_co     <= w_co_nxt;
            r_ov     <= w_ov_nxt;
            r_z      <= w_z_nxt;
            r_p      <= w_p_nxt;
            r_g      <= w_g_nxt;
        end
    end

    assign bus.ready_in     = w_ready_in;
    assign bus.valid_out    = r_valid;
    assign bus.resultado    = r_res;
    assign bus.resultado_hi = r_res_hi;
    assign bus.carry_out    = r_co;
    assign bus.overflow     = r_ov;
    assign bus.zero         = r_z;
    assign bus.propagado    = r_p;
    assign bus.gerado       = r_g;
endmodule

// File: tb/tb_ula_param_seq.sv
// Bench for ula_param_seq: directed table, hand sequences and randomized ops vs a model.
module tb_ula_param_seq;
    localparam int unsigned N = 8;

    typedef struct packed {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic         co;
        logic         ov;
        logic         z;
        logic         p;
        logic         g;
    } exp_t;

    typedef struct packed {
        logic [2:0]   sel;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        exp_t         e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    ula_param_seq_if #(.N(N)) bus ();

    ula_param_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the operation definitions, plain arithmetic only
    function automatic exp_t model(input logic [2:0] sel, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic cin);
        exp_t           e;
        logic [N-1:0]   bp;
        logic [N:0]     s;
        logic [N:0]     t;
        logic [2*N-1:0] prod;
        e = '0;
        case (sel)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = ~a;
            3'd3: e.res = ~(a & b);
            3'd4, 3'd5: begin
                bp    = (sel == 3'd5) ? ~b : b;
                s     = {1'b0, a} + {1'b0, bp} + ((sel == 3'd5) ? 1'b1 : cin);
                t     = {1'b0, a} + {1'b0, bp};
                e.res = s[N-1:0];
                e.co  = s[N];
                e.ov  = (a[N-1] == bp[N-1]) && (e.res[N-1] != a[N-1]);
                e.p   = &(a | bp);
                e.g   = t[N];
            end
            3'd6: begin
                prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
                e.res = prod[N-1:0];
                e.hi  = prod[2*N-1:N];
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == '0) && (e.hi == '0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [2:0] sel, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic cin, input logic [N-1:0] res, input logic [N-1:0] hi,
                                input logic co, input logic ov, input logic z, input logic p,
                                input logic g);
        vec_t v;
        v.sel = sel;   v.a = a;     v.b = b;     v.cin = cin;
        v.e.res = res; v.e.hi = hi; v.e.co = co; v.e.ov = ov;
        v.e.z = z;     v.e.p = p;   v.e.g = g;
        return v;
    endfunction

    task automatic check_out(input string pfx, input exp_t e);
        chk({pfx, ".resultado"}, 64'(bus.resultado), 64'(e.res));
        chk({pfx, ".resultado_hi"}, 64'(bus.resultado_hi), 64'(e.hi));
        chk({pfx, ".flags(co,ov,z,p,g)"},
            64'({bus.carry_out, bus.overflow, bus.zero, bus.propagado, bus.gerado}),
            64'({e.co, e.ov, e.z, e.p, e.g}));
    endtask

    // Called at a negedge with the result register empty; leaves result held (ready_out=0)
    task automatic run_op(input string pfx, input logic [2:0] sel, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic cin);
        int   lat;
        int   w;
        logic rdy_low;
        bus.seletor   = sel;
        bus.A         = a;
        bus.B         = b;
        bus.carry_in  = cin;
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        w = 0;
        while (!bus.ready_in && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ready_in) chk({pfx, ".ready_in_wait"}, 64'(bus.ready_in), 64'd1);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        lat     = 1;
        rdy_low = 1'b1;
        @(negedge clk);
        while (!bus.valid_out && lat < 40) begin
            if (bus.ready_in) rdy_low = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({pfx, ".latency"}, 64'(lat), (sel == 3'd6) ? 64'(N + 1) : 64'd1);
        if (sel == 3'd6) chk({pfx, ".ready_in_low_during_mul"}, 64'(rdy_low), 64'd1);
    endtask

    task automatic drain();
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1 bus.ready_out = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[10];
    exp_t e;

    initial begin
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.seletor   = '0;
        bus.carry_in  = 1'b0;

        vecs[0] = mk(3'd4, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1, 0, 1, 1, 1);
        vecs[1] = mk(3'd5, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1, 1, 0, 0, 1);
        vecs[2] = mk(3'd5, 8'h01, 8'h02, 1'b1, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
        vecs[3] = mk(3'd6, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 0, 0, 0, 0, 0);
        vecs[4] = mk(3'd2, 8'hA5, 8'h0F, 1'b0, 8'h5A, 8'h00, 0, 0, 0, 0, 0);
        vecs[5] = mk(3'd3, 8'hA5, 8'h0F, 1'b0, 8'hFA, 8'h00, 0, 0, 0, 0, 0);
        vecs[6] = mk(3'd7, 8'hA5, 8'h0F, 1'b1, 8'h00, 8'h00, 0, 0, 1, 0, 0);
        vecs[7] = mk(3'd4, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 0, 1, 0, 0, 0);
        vecs[8] = mk(3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 0, 0, 0, 0, 0);
        vecs[9] = mk(3'd1, 8'hA5, 8'h0F, 1'b0, 8'hAF, 8'h00, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.ready_in", 64'(bus.ready_in), 64'd0);
        chk("reset.valid_out", 64'(bus.valid_out), 64'd0);
        check_out("reset", '0);
        rst = 1'b0;
        #1 chk("post_reset.ready_in", 64'(bus.ready_in), 64'd1);
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
            check_out($sformatf("vec%0d", i), vecs[i].e);
            drain();
            chk($sformatf("vec%0d.drained", i), 64'(bus.valid_out), 64'd0);
        end

        // Back-to-back throughput with ready_out held high
        bus.ready_out = 1'b1;
        bus.seletor = 3'd4; bus.A = 8'h10; bus.B = 8'h20; bus.carry_in = 1'b0;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 begin bus.seletor = 3'd1; bus.A = 8'h01; bus.B = 8'h02; end
        @(negedge clk);
        chk("b2b.first_valid", 64'(bus.valid_out), 64'd1);
        chk("b2b.first_res", 64'(bus.resultado), 64'h30);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        @(negedge clk);
        chk("b2b.second_valid", 64'(bus.valid_out), 64'd1);
        chk("b2b.second_res", 64'(bus.resultado), 64'h03);
        @(negedge clk);
        chk("b2b.cleared", 64'(bus.valid_out), 64'd0);
        bus.ready_out = 1'b0;

        // Backpressure: AND held for 3 cycles while an OR waits
        bus.seletor = 3'd0; bus.A = 8'hF0; bus.B = 8'h3C; bus.valid_in = 1'b1;
        @(posedge clk);
        #1 begin bus.seletor = 3'd1; bus.A = 8'hF0; bus.B = 8'h0C; end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d.valid", k), 64'(bus.valid_out), 64'd1);
            chk($sformatf("bp.hold%0d.res", k), 64'(bus.resultado), 64'h30);
            chk($sformatf("bp.hold%0d.ready_in", k), 64'(bus.ready_in), 64'd0);
        end
        bus.ready_out = 1'b1;
        #1 chk("bp.ready_in_on_drain", 64'(bus.ready_in), 64'd1);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        @(negedge clk);
        chk("bp.or_valid", 64'(bus.valid_out), 64'd1);
        chk("bp.or_res", 64'(bus.resultado), 64'hFC);
        @(negedge clk);
        chk("bp.cleared", 64'(bus.valid_out), 64'd0);
        chk("bp.data_kept", 64'(bus.resultado), 64'hFC);
        bus.ready_out = 1'b0;

        // Reset on the 4th MUL iteration cycle
        bus.seletor = 3'd6; bus.A = 8'h12; bus.B = 8'h34; bus.valid_in = 1'b1;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mulrst.valid", 64'(bus.valid_out), 64'd0);
        chk("mulrst.ready_in", 64'(bus.ready_in), 64'd0);
        check_out("mulrst", '0);
        rst = 1'b0;
        #1 chk("mulrst.ready_after", 64'(bus.ready_in), 64'd1);
        @(negedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   s;
            logic [N-1:0] a;
            logic [N-1:0] b;
            logic         c;
            s = 3'($urandom_range(0, 7));
            a = N'($urandom);
            b = N'($urandom);
            c = 1'($urandom);
            e = model(s, a, b, c);
            run_op($sformatf("rnd%0d", i), s, a, b, c);
            check_out($sformatf("rnd%0d", i), e);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
